// File: rtl/room_sequencer.sv
// Purpose: steps the current maze cell on an exit request, reloads the tile code and issues a respawn point.
// Latency: cell steps on the frame edge; tile_code/tile_valid/respawn_valid follow 2 cycles later.
// Backpressure: none; exit_req is a level, sampled only in IDLE, and out-of-grid requests pulse blocked.
module room_sequencer #(
    parameter logic [2:0] START_X  = 3'd0,
    parameter logic [2:0] START_Y  = 3'd0,
    parameter logic [2:0] GOAL_X   = 3'd7,
    parameter logic [2:0] GOAL_Y   = 3'd7,
    parameter logic [9:0] X_LEFT   = 10'd200,
    parameter logic [9:0] X_RIGHT  = 10'd620,
    parameter logic [9:0] Y_TOP    = 10'd106,
    parameter logic [9:0] Y_BOTTOM = 10'd358,
    parameter logic [9:0] START_PX = 10'd410,
    parameter logic [9:0] START_PY = 10'd240
) (
    input  logic       CLOCK_25,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic [3:0] exit_req,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    output logic [5:0] rom_addr,
    input  logic [3:0] rom_data,
    output logic [2:0] cell_x,
    output logic [2:0] cell_y,
    output logic [3:0] tile_code,
    output logic       tile_valid,
    output logic       respawn_valid,
    output logic [9:0] respawn_x,
    output logic [9:0] respawn_y,
    output logic       blocked,
    output logic       goal_reached
);

    typedef enum logic [2:0] {FETCH, LOAD, IDLE, WAIT_FRAME, DONE} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_t;

    state_t     state, state_nxt;
    dir_t       dir, dir_nxt;
    dir_t       req_dir;
    logic       req_any, req_ok;
    logic [9:0] lat_x, lat_x_nxt, lat_y, lat_y_nxt;
    logic [2:0] cell_x_nxt, cell_y_nxt;
    logic [3:0] tile_code_nxt;
    logic       tile_valid_nxt, respawn_valid_nxt, blocked_nxt, goal_reached_nxt;
    logic [9:0] respawn_x_nxt, respawn_y_nxt;

    // The ROM is addressed straight from the cell registers; FETCH gives it one edge to capture.
    assign rom_addr = {cell_y, cell_x};

    // Pick the highest-priority requested direction and check that its target stays inside the grid.
    always_comb begin
        req_any = |exit_req;
        req_dir = DIR_LEFT;
        req_ok  = 1'b0;
        if (exit_req[3]) begin
            req_dir = DIR_UP;
            req_ok  = (cell_y != 3'd0);
        end else if (exit_req[2]) begin
            req_dir = DIR_RIGHT;
            req_ok  = (cell_x != 3'd7);
        end else if (exit_req[1]) begin
            req_dir = DIR_DOWN;
            req_ok  = (cell_y != 3'd7);
        end else if (exit_req[0]) begin
            req_dir = DIR_LEFT;
            req_ok  = (cell_x != 3'd0);
        end
    end

    // Next-state and next-output logic; pulses default low, everything else holds.
    always_comb begin
        state_nxt         = state;
        dir_nxt           = dir;
        lat_x_nxt         = lat_x;
        lat_y_nxt         = lat_y;
        cell_x_nxt        = cell_x;
        cell_y_nxt        = cell_y;
        tile_code_nxt     = tile_code;
        tile_valid_nxt    = tile_valid;
        respawn_valid_nxt = 1'b0;
        respawn_x_nxt     = respawn_x;
        respawn_y_nxt     = respawn_y;
        blocked_nxt       = 1'b0;
        goal_reached_nxt  = goal_reached;
        case (state)
            FETCH: state_nxt = LOAD;
            LOAD: begin
                tile_code_nxt     = rom_data;
                tile_valid_nxt    = 1'b1;
                respawn_valid_nxt = 1'b1;
                if (cell_x == GOAL_X && cell_y == GOAL_Y) begin
                    goal_reached_nxt = 1'b1;
                    state_nxt        = DONE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (req_any) begin
                    if (req_ok) begin
                        dir_nxt        = req_dir;
                        lat_x_nxt      = player_x;
                        lat_y_nxt      = player_y;
                        tile_valid_nxt = 1'b0;
                        state_nxt      = WAIT_FRAME;
                    end else begin
                        blocked_nxt = 1'b1;
                    end
                end
            end
            WAIT_FRAME: begin
                if (frame_start) begin
                    state_nxt = FETCH;
                    case (dir)
                        DIR_UP: begin
                            cell_y_nxt    = cell_y - 3'd1;
                            respawn_x_nxt = lat_x;
                            respawn_y_nxt = Y_BOTTOM;
                        end
                        DIR_DOWN: begin
                            cell_y_nxt    = cell_y + 3'd1;
                            respawn_x_nxt = lat_x;
                            respawn_y_nxt = Y_TOP;
                        end
                        DIR_RIGHT: begin
                            cell_x_nxt    = cell_x + 3'd1;
                            respawn_x_nxt = X_LEFT;
                            respawn_y_nxt = lat_y;
                        end
                        default: begin
                            cell_x_nxt    = cell_x - 3'd1;
                            respawn_x_nxt = X_RIGHT;
                            respawn_y_nxt = lat_y;
                        end
                    endcase
                end
            end
            DONE: goal_reached_nxt = 1'b1;
            default: state_nxt = FETCH;
        endcase
    end

    // State and output registers; reset restarts at the start cell with a fresh fetch.
    always_ff @(posedge CLOCK_25 or negedge reset_n) begin
        if (!reset_n) begin
            state         <= FETCH;
            dir           <= DIR_UP;
            lat_x         <= '0;
            lat_y         <= '0;
            cell_x        <= START_X;
            cell_y        <= START_Y;
            tile_code     <= '0;
            tile_valid    <= 1'b0;
            respawn_valid <= 1'b0;
            respawn_x     <= START_PX;
            respawn_y     <= START_PY;
            blocked       <= 1'b0;
            goal_reached  <= 1'b0;
        end else begin
            state         <= state_nxt;
            dir           <= dir_nxt;
            lat_x         <= lat_x_nxt;
            lat_y         <= lat_y_nxt;
            cell_x        <= cell_x_nxt;
            cell_y        <= cell_y_nxt;
            tile_code     <= tile_code_nxt;
            tile_valid    <= tile_valid_nxt;
            respawn_valid <= respawn_valid_nxt;
            respawn_x     <= respawn_x_nxt;
            respawn_y     <= respawn_y_nxt;
            blocked       <= blocked_nxt;
            goal_reached  <= goal_reached_nxt;
        end
    end

endmodule

// File: tb/tb_room_sequencer.sv
// Purpose: directed plus random room walks against a cell/tile model of the maze sequencer.
// Latency: checks land on the negedge after each active edge.
// Backpressure: none; every wait is a fixed number of cycles.
module tb_room_sequencer;

    logic       CLOCK_25 = 1'b0;
    logic       reset_n;
    logic       frame_start;
    logic [3:0] exit_req;
    logic [9:0] player_x, player_y;
    logic [5:0] rom_addr;
    logic [3:0] rom_data;
    logic [2:0] cell_x, cell_y;
    logic [3:0] tile_code;
    logic       tile_valid, respawn_valid, blocked, goal_reached;
    logic [9:0] respawn_x, respawn_y;

    logic [3:0] rom [64];

    int  n_cmp = 0;
    int  n_err = 0;
    int  m_x, m_y;
    logic [3:0] m_tile;
    bit  m_done;

    room_sequencer #(
        .START_X(3'd0), .START_Y(3'd0), .GOAL_X(3'd7), .GOAL_Y(3'd7),
        .X_LEFT(10'd200), .X_RIGHT(10'd620), .Y_TOP(10'd106), .Y_BOTTOM(10'd358),
        .START_PX(10'd410), .START_PY(10'd240)
    ) dut (
        .CLOCK_25(CLOCK_25), .reset_n(reset_n), .frame_start(frame_start),
        .exit_req(exit_req), .player_x(player_x), .player_y(player_y),
        .rom_addr(rom_addr), .rom_data(rom_data), .cell_x(cell_x), .cell_y(cell_y),
        .tile_code(tile_code), .tile_valid(tile_valid), .respawn_valid(respawn_valid),
        .respawn_x(respawn_x), .respawn_y(respawn_y), .blocked(blocked),
        .goal_reached(goal_reached)
    );

    always #20 CLOCK_25 = ~CLOCK_25;

    // Synchronous maze ROM with one cycle of read latency.
    always @(posedge CLOCK_25) rom_data <= rom[rom_addr];

    function automatic logic [5:0] addr6(input int x, input int y);
        return 6'(y * 8 + x);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_25);
        @(negedge CLOCK_25);
    endtask

    // Called on the negedge right after reset is released: expects the start-cell reload.
    task automatic reload_check();
        m_x = 0; m_y = 0; m_done = 1'b0;
        tick();
        chk("rl_tv_e1", 32'(tile_valid), 0);
        chk("rl_rv_e1", 32'(respawn_valid), 0);
        tick();
        m_tile = rom[addr6(m_x, m_y)];
        chk("rl_tile", 32'(tile_code), 32'(m_tile));
        chk("rl_tv_e2", 32'(tile_valid), 1);
        chk("rl_rv_e2", 32'(respawn_valid), 1);
        chk("rl_rx", 32'(respawn_x), 410);
        chk("rl_ry", 32'(respawn_y), 240);
        chk("rl_cx", 32'(cell_x), 0);
        chk("rl_cy", 32'(cell_y), 0);
        chk("rl_goal", 32'(goal_reached), 0);
        tick();
        chk("rl_rv_e3", 32'(respawn_valid), 0);
    endtask

    // One exit attempt from IDLE or DONE, judged entirely by the model.
    task automatic do_move(input logic [3:0] req, input logic [9:0] px, input logic [9:0] py,
                           input int wait_n, input bit coincide);
        int tx, ty, erx, ery;
        bit ok;
        tx = m_x; ty = m_y;
        if (req[3])      begin ty = m_y - 1; erx = int'(px); ery = 358; end
        else if (req[2]) begin tx = m_x + 1; erx = 200; ery = int'(py); end
        else if (req[1]) begin ty = m_y + 1; erx = int'(px); ery = 106; end
        else             begin tx = m_x - 1; erx = 620; ery = int'(py); end
        ok = (tx >= 0) && (tx <= 7) && (ty >= 0) && (ty <= 7);
        exit_req = req; player_x = px; player_y = py; frame_start = coincide;
        tick();
        exit_req = 4'd0; frame_start = 1'b0;
        if (m_done) begin
            chk("done_blocked", 32'(blocked), 0);
            chk("done_tv", 32'(tile_valid), 1);
            chk("done_goal", 32'(goal_reached), 1);
            tick();
            chk("done_cx", 32'(cell_x), 32'(m_x));
            chk("done_cy", 32'(cell_y), 32'(m_y));
            chk("done_rv", 32'(respawn_valid), 0);
            return;
        end
        if (!ok) begin
            chk("blk_pulse", 32'(blocked), 1);
            chk("blk_tv", 32'(tile_valid), 1);
            chk("blk_cx", 32'(cell_x), 32'(m_x));
            chk("blk_cy", 32'(cell_y), 32'(m_y));
            tick();
            chk("blk_low", 32'(blocked), 0);
            return;
        end
        chk("exit_tv", 32'(tile_valid), 0);
        chk("exit_blocked", 32'(blocked), 0);
        chk("exit_tile_hold", 32'(tile_code), 32'(m_tile));
        for (int i = 0; i < wait_n; i++) begin
            exit_req = 4'($urandom_range(1, 15));
            player_x = 10'($urandom);
            player_y = 10'($urandom);
            tick();
            chk("wait_cx", 32'(cell_x), 32'(m_x));
            chk("wait_cy", 32'(cell_y), 32'(m_y));
            chk("wait_blocked", 32'(blocked), 0);
            chk("wait_tv", 32'(tile_valid), 0);
        end
        exit_req = 4'($urandom_range(0, 15));
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0; exit_req = 4'd0;
        m_x = tx; m_y = ty;
        chk("step_cx", 32'(cell_x), 32'(m_x));
        chk("step_cy", 32'(cell_y), 32'(m_y));
        chk("step_addr", 32'(rom_addr), 32'(addr6(m_x, m_y)));
        chk("step_tv", 32'(tile_valid), 0);
        tick();
        chk("fetch_tv", 32'(tile_valid), 0);
        chk("fetch_rv", 32'(respawn_valid), 0);
        tick();
        m_tile = rom[addr6(m_x, m_y)];
        if (m_x == 7 && m_y == 7) m_done = 1'b1;
        chk("load_tile", 32'(tile_code), 32'(m_tile));
        chk("load_tv", 32'(tile_valid), 1);
        chk("load_rv", 32'(respawn_valid), 1);
        chk("load_rx", 32'(respawn_x), 32'(erx));
        chk("load_ry", 32'(respawn_y), 32'(ery));
        chk("load_goal", 32'(goal_reached), 32'(m_done));
        tick();
        chk("post_rv", 32'(respawn_valid), 0);
        chk("post_tv", 32'(tile_valid), 1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 4'($urandom);
        rom[0] = 4'd10;
        rom[1] = 4'd3;
        reset_n = 1'b0; frame_start = 1'b0; exit_req = 4'd0;
        player_x = 10'd0; player_y = 10'd0;
        m_tile = 4'd0;
        @(negedge CLOCK_25);
        @(negedge CLOCK_25);
        chk("rst_tile", 32'(tile_code), 0);
        chk("rst_tv", 32'(tile_valid), 0);
        chk("rst_rv", 32'(respawn_valid), 0);
        chk("rst_blk", 32'(blocked), 0);
        chk("rst_goal", 32'(goal_reached), 0);
        chk("rst_rx", 32'(respawn_x), 410);
        chk("rst_ry", 32'(respawn_y), 240);
        chk("rst_addr", 32'(rom_addr), 0);
        reset_n = 1'b1;
        reload_check();

        // Left held at column 0: one blocked pulse per cycle, nothing else moves.
        exit_req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_blk", 32'(blocked), 1);
            chk("hold_tv", 32'(tile_valid), 1);
            chk("hold_cx", 32'(cell_x), 0);
        end
        exit_req = 4'd0;
        tick();
        chk("hold_blk_low", 32'(blocked), 0);
        do_move(4'b1000, 10'd300, 10'd300, 0, 1'b0);

        // Right with player_y=300, then walk to (3,3); one step has a coincident frame pulse.
        do_move(4'b0100, 10'd123, 10'd300, 3, 1'b0);
        do_move(4'b0100, 10'($urandom), 10'($urandom), 0, 1'b1);
        do_move(4'b0100, 10'($urandom), 10'($urandom), 1, 1'b0);
        do_move(4'b0010, 10'($urandom), 10'($urandom), 2, 1'b0);
        do_move(4'b0010, 10'($urandom), 10'($urandom), 0, 1'b0);
        do_move(4'b0010, 10'($urandom), 10'($urandom), 1, 1'b1);
        do_move(4'b1111, 10'd77, 10'd400, 2, 1'b0);

        // Reset while waiting for a frame.
        exit_req = 4'b0010;
        tick();
        exit_req = 4'd0;
        chk("mid_wait_tv", 32'(tile_valid), 0);
        #5 reset_n = 1'b0;
        #1;
        chk("mid_rst_cx", 32'(cell_x), 0);
        chk("mid_rst_cy", 32'(cell_y), 0);
        chk("mid_rst_tv", 32'(tile_valid), 0);
        chk("mid_rst_tile", 32'(tile_code), 0);
        @(negedge CLOCK_25);
        reset_n = 1'b1;
        reload_check();

        // Random walk, then finish deterministically at the goal.
        for (int i = 0; i < 20; i++)
            do_move(4'($urandom_range(1, 15)), 10'($urandom), 10'($urandom),
                    $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 20 && !m_done; i++) begin
            if (m_x < 7) do_move(4'b0100, 10'($urandom), 10'($urandom), 1, 1'b0);
            else         do_move(4'b0010, 10'($urandom), 10'($urandom), 1, 1'b0);
        end
        chk("goal_model", 32'(m_done), 1);
        chk("goal_sticky", 32'(goal_reached), 1);
        do_move(4'b1000, 10'($urandom), 10'($urandom), 0, 1'b0);
        do_move(4'b0100, 10'($urandom), 10'($urandom), 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/room_sequencer.md
# room_sequencer

Sequences room transitions for the 8x8 maze. When the player leaves the visible room through an opening, the block waits for the next frame boundary and steps the current cell coordinate. It then fetches the new tile code from the maze ROM and issues a respawn position on the opposite edge. It sits between the player block (exit requests, position), the VGA counters (frame pulse) and the tile renderer/collision logic (tile code).

## Interface
Parameters:
- START_X, 0, initial cell column (0..7)
- START_Y, 0, initial cell row (0..7)
- GOAL_X, 7, goal cell column
- GOAL_Y, 7, goal cell row
- X_LEFT, 200, respawn x when entering through the left edge
- X_RIGHT, 620, respawn x when entering through the right edge
- Y_TOP, 106, respawn y when entering through the top edge
- Y_BOTTOM, 358, respawn y when entering through the bottom edge
- START_PX, 410, respawn x after reset
- START_PY, 240, respawn y after reset

Ports:
- CLOCK_25  in  1  pixel clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at h_counter==0, v_counter==0
- exit_req  in  4  {up,right,down,left}; level, player touching an outer edge opening
- player_x  in  10  current player x
- player_y  in  10  current player y
- rom_addr  out  6  maze ROM address {cell_y,cell_x}
- rom_data  in  4  tile code; synchronous ROM, 1-cycle latency
- cell_x  out  3  current cell column
- cell_y  out  3  current cell row
- tile_code  out  4  tile code of current cell
- tile_valid  out  1  tile_code is current
- respawn_valid  out  1  one-cycle pulse: player loads respawn_x/y
- respawn_x  out  10  new player x
- respawn_y  out  10  new player y
- blocked  out  1  one-cycle pulse: exit toward outside of grid rejected
- goal_reached  out  1  sticky: goal cell entered

## Operation
- States: FETCH, LOAD, IDLE, WAIT_FRAME, DONE.
- Reset (reset_n low, async):
  - cell = (START_X, START_Y), state FETCH.
  - tile_code=0, tile_valid=0, respawn_valid=0, blocked=0, goal_reached=0.
  - respawn_x=START_PX, respawn_y=START_PY.
- rom_addr = {cell_y, cell_x}, combinational from the cell registers.
- FETCH: ROM captures; next LOAD.
- LOAD:
  - tile_code <= rom_data, tile_valid <= 1.
  - respawn_valid pulses.
  - Next DONE if cell == goal, else IDLE. On the post-reset load, goal_reached is also set if START equals GOAL.
- IDLE: exit_req sampled, priority up > right > down > left.
  - Target cell in grid (up: y-1, right: x+1, down: y+1, left: x-1): latch direction and player_x/player_y, clear tile_valid, go WAIT_FRAME.
  - Target outside grid (e.g. left at x=0): pulse blocked, stay IDLE, no state change.
- WAIT_FRAME:
  - exit_req ignored.
  - On frame_start: apply the coordinate step, go FETCH.
- Respawn position on the step:
  - up: y=Y_BOTTOM, x=latched player_x.
  - down: y=Y_TOP, x=latched player_x.
  - right: x=X_LEFT, y=latched player_y.
  - left: x=X_RIGHT, y=latched player_y.
- DONE: goal_reached=1. All exit_req ignored; blocked never pulses. Only reset leaves DONE.
- Coordinates are 3-bit unsigned and never wrap. Out-of-range moves are rejected, not wrapped.
- tile_code holds its old value while tile_valid=0; the renderer blanks on !tile_valid.

## Timing
- After reset release: FETCH edge 1, LOAD edge 2. tile_valid and respawn_valid high after edge 2; respawn_valid low after edge 3.
- exit_req seen at edge t (IDLE): state WAIT_FRAME and tile_valid=0 after edge t.
- frame_start sampled at edge k: cell updated after k, ROM data after k+1, tile_code/tile_valid/respawn_valid after k+2. Transition latency is 2 cycles from the frame edge.
- frame_start arriving in the same cycle as an IDLE exit_req is not used; the block waits for the next frame.
- respawn_valid and blocked are exactly one cycle wide.
- blocked is asserted the cycle after the edge that sampled the rejected request. It repeats every cycle while the request persists.
- Reset mid-transition aborts to FETCH of START immediately and asynchronously; the latched direction is discarded.

## Test plan
- Reset with START=(0,0), ROM[0]=10:
  - tile_code=10, tile_valid=1 and respawn (410,240) pulse on cycle 2 after release.
  - cell=(0,0).
- From (0,0), exit_req=right with player_y=300, then frame_start:
  - cell=(1,0), rom_addr=1, tile_code=ROM[1] two cycles after frame_start.
  - respawn=(200,300) one-cycle pulse.
- From (0,0), exit_req=left held 3 cycles:
  - blocked pulses 3 times.
  - state IDLE, cell unchanged, tile_valid stays 1.
- exit_req=1111 at (3,3):
  - up wins: cell=(3,2), respawn_y=358.
  - Second exit_req during WAIT_FRAME is ignored.
- Walk to (7,7):
  - goal_reached=1 after LOAD.
  - Subsequent exit_req=up produces no transition and no blocked pulse.
- reset_n low for 1 cycle while in WAIT_FRAME:
  - cell returns to START, tile_valid=0 immediately.
  - Normal reload follows 2 cycles after release.
